// File: rtl/fft_but_sched.sv
// fft_but_sched: address/control sequencer for the in-place radix-4/radix-2 FFT.
// It issues one butterfly per cycle: four read addresses, the twiddle base index
// and the butterfly mode. It then issues the matching write-back addresses and
// write enable, delayed by the RAM read latency plus the butterfly latency.
// Optional build macro FFT_SCHED_CYCLE_CNT_EN adds the 16-bit oCYCLES counter.
//
// state | meaning
// IDLE  | waiting for iSTART
// RUN   | issuing one butterfly per cycle, k = 0..N/4-1
// DRAIN | waiting RD_LAT+BUT_LAT cycles so the stage's writes land
// DONE  | one-cycle oDONE pulse, then back to IDLE
module fft_but_sched #(
  parameter int N_LOG2  = 8,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 1
) (
  input  logic                                     iCLK,
  input  logic                                     iRESET,
  input  logic                                     iSTART,
  output logic                                     oBUSY,
  output logic                                     oDONE,
  output logic                                     oRD_EN,
  output logic [N_LOG2-1:0]                        oRD_ADDR0,
  output logic [N_LOG2-1:0]                        oRD_ADDR1,
  output logic [N_LOG2-1:0]                        oRD_ADDR2,
  output logic [N_LOG2-1:0]                        oRD_ADDR3,
  output logic [((N_LOG2 > 2) ? N_LOG2-2 : 1)-1:0] oTW_IDX,
  output logic                                     oBUT_SEL,
  output logic                                     oWE,
  output logic [N_LOG2-1:0]                        oWR_ADDR0,
  output logic [N_LOG2-1:0]                        oWR_ADDR1,
  output logic [N_LOG2-1:0]                        oWR_ADDR2,
  output logic [N_LOG2-1:0]                        oWR_ADDR3,
  output logic [3:0]                               oSTAGE
`ifdef FFT_SCHED_CYCLE_CNT_EN
  ,
  output logic [15:0]                              oCYCLES
`endif
);

  localparam int NW   = N_LOG2;
  // N_LOG2 = 2 leaves a zero-width k and twiddle; keep one bit so the widths stay legal
  localparam int KW   = (N_LOG2 > 2) ? N_LOG2-2 : 1;
  localparam int TWW  = KW;
  localparam int S4   = N_LOG2 / 2;
  localparam int NSTG = S4 + (N_LOG2 % 2);
  localparam int WL   = RD_LAT + BUT_LAT;

  localparam logic [KW-1:0] KLAST    = KW'((1 << (N_LOG2-2)) - 1);
  localparam logic [3:0]    LAST_STG = 4'(NSTG - 1);
  localparam logic [2:0]    DRAIN_LD = 3'(WL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [3:0]      stage;
  logic [KW-1:0]   k;
  logic [2:0]      dcnt;
  logic            mode_q;

  logic            issue;
  logic [3:0]      ld_stage;
  logic [KW-1:0]   ld_k;
  logic            ld_r2;
  int              ld_log2q;
  logic [NW-1:0]   kk;
  logic [NW-1:0]   jmask;
  logic [NW-1:0]   jv;
  logic [NW-1:0]   base;
  logic [NW-1:0]   ld_addr [4];
  logic [TWW-1:0]  ld_tw;

  logic            sel_dly [RD_LAT];
  logic            we_dly  [WL];
  logic [4*NW-1:0] wa_dly  [WL];

  assign oSTAGE = stage;

  // Pick the (stage, k) that the next issued butterfly will use, and whether one is issued at all
  always_comb begin
    issue    = 1'b0;
    ld_stage = 4'd0;
    ld_k     = '0;
    case (state)
      IDLE:  issue = iSTART;
      RUN: begin
        issue    = (k != KLAST);
        ld_stage = stage;
        ld_k     = k + KW'(1);
      end
      DRAIN: begin
        issue    = (dcnt == 3'd0) && (stage != LAST_STG);
        ld_stage = stage + 4'd1;
      end
      default: ;
    endcase
  end

  // Butterfly address generation; q is a power of two so div/mod reduce to masks and shifts
  always_comb begin
    ld_r2    = (ld_stage >= 4'(S4));
    ld_log2q = ld_r2 ? 0 : (N_LOG2 - 2 - 2 * int'(ld_stage));
    kk       = NW'(ld_k);
    jmask    = (NW'(1) << ld_log2q) - NW'(1);
    jv       = kk & jmask;
    base     = ((kk & ~jmask) << 2) | jv;
    ld_tw    = '0;
    for (int m = 0; m < 4; m++) ld_addr[m] = '0;
    if (ld_r2) begin
      for (int m = 0; m < 4; m++) ld_addr[m] = (kk << 2) | NW'(m);
    end else begin
      for (int m = 0; m < 4; m++) ld_addr[m] = base | (NW'(m) << ld_log2q);
      ld_tw = TWW'(jv << (2 * int'(ld_stage)));
    end
  end

  // Sequencer FSM with registered read-side outputs
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state     <= IDLE;
      stage     <= 4'd0;
      k         <= '0;
      dcnt      <= 3'd0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oRD_EN    <= 1'b0;
      oRD_ADDR0 <= '0;
      oRD_ADDR1 <= '0;
      oRD_ADDR2 <= '0;
      oRD_ADDR3 <= '0;
      oTW_IDX   <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            state <= RUN;
            stage <= 4'd0;
            k     <= '0;
            oBUSY <= 1'b1;
          end
        end
        RUN: begin
          if (k == KLAST) begin
            state <= DRAIN;
            dcnt  <= DRAIN_LD;
          end else begin
            k <= k + KW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == 3'd0) begin
            if (stage == LAST_STG) begin
              state <= DONE;
              oDONE <= 1'b1;
            end else begin
              state <= RUN;
              stage <= stage + 4'd1;
              k     <= '0;
            end
          end else begin
            dcnt <= dcnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          oDONE <= 1'b0;
          oBUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Addresses hold outside RUN; strobe, twiddle and mode drop to 0
      if (issue) begin
        oRD_EN    <= 1'b1;
        oRD_ADDR0 <= ld_addr[0];
        oRD_ADDR1 <= ld_addr[1];
        oRD_ADDR2 <= ld_addr[2];
        oRD_ADDR3 <= ld_addr[3];
        oTW_IDX   <= ld_tw;
        mode_q    <= ld_r2;
      end else begin
        oRD_EN  <= 1'b0;
        oTW_IDX <= '0;
        mode_q  <= 1'b0;
      end
    end
  end

  // Delay lines aligning the mode to RAM data and write-back to butterfly outputs
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < RD_LAT; i++) sel_dly[i] <= 1'b0;
      for (int i = 0; i < WL; i++) begin
        we_dly[i] <= 1'b0;
        wa_dly[i] <= '0;
      end
    end else begin
      sel_dly[0] <= mode_q;
      for (int i = 1; i < RD_LAT; i++) sel_dly[i] <= sel_dly[i-1];
      we_dly[0] <= oRD_EN;
      wa_dly[0] <= {oRD_ADDR3, oRD_ADDR2, oRD_ADDR1, oRD_ADDR0};
      for (int i = 1; i < WL; i++) begin
        we_dly[i] <= we_dly[i-1];
        wa_dly[i] <= wa_dly[i-1];
      end
    end
  end

  assign oBUT_SEL = sel_dly[RD_LAT-1];
  assign oWE      = we_dly[WL-1];
  assign {oWR_ADDR3, oWR_ADDR2, oWR_ADDR1, oWR_ADDR0} = wa_dly[WL-1];

`ifdef FFT_SCHED_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on start, counts while busy, saturating, holds when idle
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oCYCLES <= 16'd0;
    end else if (state == IDLE && iSTART) begin
      oCYCLES <= 16'd0;
    end else if (oBUSY && oCYCLES != 16'hFFFF) begin
      oCYCLES <= oCYCLES + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_but_sched.sv
// Bench for fft_but_sched: N_LOG2=4 and N_LOG2=3 instances driven by one
// scenario table and a few hand-written sequences, checked against a
// scoreboard built from the address formulas.
module tb_fft_but_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, sel3;
  logic start4, start3;
  assign start4 = start & ~sel3;
  assign start3 = start & sel3;

  logic       r4_busy, r4_done, r4_rd_en, r4_bsel, r4_we;
  logic [3:0] r4_ra0, r4_ra1, r4_ra2, r4_ra3, r4_wa0, r4_wa1, r4_wa2, r4_wa3, r4_stg;
  logic [1:0] r4_tw;
  logic       r3_busy, r3_done, r3_rd_en, r3_bsel, r3_we;
  logic [2:0] r3_ra0, r3_ra1, r3_ra2, r3_ra3, r3_wa0, r3_wa1, r3_wa2, r3_wa3;
  logic [3:0] r3_stg;
  logic [0:0] r3_tw;
`ifdef FFT_SCHED_CYCLE_CNT_EN
  logic [15:0] r4_cyc, r3_cyc;
`endif

  fft_but_sched #(.N_LOG2(4), .RD_LAT(1), .BUT_LAT(1)) u_dut4 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start4),
    .oBUSY(r4_busy), .oDONE(r4_done), .oRD_EN(r4_rd_en),
    .oRD_ADDR0(r4_ra0), .oRD_ADDR1(r4_ra1), .oRD_ADDR2(r4_ra2), .oRD_ADDR3(r4_ra3),
    .oTW_IDX(r4_tw), .oBUT_SEL(r4_bsel), .oWE(r4_we),
    .oWR_ADDR0(r4_wa0), .oWR_ADDR1(r4_wa1), .oWR_ADDR2(r4_wa2), .oWR_ADDR3(r4_wa3),
    .oSTAGE(r4_stg)
`ifdef FFT_SCHED_CYCLE_CNT_EN
    , .oCYCLES(r4_cyc)
`endif
  );

  fft_but_sched #(.N_LOG2(3), .RD_LAT(1), .BUT_LAT(1)) u_dut3 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start3),
    .oBUSY(r3_busy), .oDONE(r3_done), .oRD_EN(r3_rd_en),
    .oRD_ADDR0(r3_ra0), .oRD_ADDR1(r3_ra1), .oRD_ADDR2(r3_ra2), .oRD_ADDR3(r3_ra3),
    .oTW_IDX(r3_tw), .oBUT_SEL(r3_bsel), .oWE(r3_we),
    .oWR_ADDR0(r3_wa0), .oWR_ADDR1(r3_wa1), .oWR_ADDR2(r3_wa2), .oWR_ADDR3(r3_wa3),
    .oSTAGE(r3_stg)
`ifdef FFT_SCHED_CYCLE_CNT_EN
    , .oCYCLES(r3_cyc)
`endif
  );

  // Observed outputs of the instance under test, zero-extended to common widths
  logic        o_busy, o_done, o_rd_en, o_bsel, o_we;
  logic [15:0] o_ra, o_wa;
  logic [3:0]  o_stg;
  int          o_tw;
  always_comb begin
    o_busy = sel3 ? r3_busy  : r4_busy;
    o_done = sel3 ? r3_done  : r4_done;
    o_rd_en = sel3 ? r3_rd_en : r4_rd_en;
    o_bsel = sel3 ? r3_bsel  : r4_bsel;
    o_we   = sel3 ? r3_we    : r4_we;
    o_stg  = sel3 ? r3_stg   : r4_stg;
    o_tw   = sel3 ? int'(r3_tw) : int'(r4_tw);
    o_ra   = sel3 ? {1'b0, r3_ra3, 1'b0, r3_ra2, 1'b0, r3_ra1, 1'b0, r3_ra0}
                  : {r4_ra3, r4_ra2, r4_ra1, r4_ra0};
    o_wa   = sel3 ? {1'b0, r3_wa3, 1'b0, r3_wa2, 1'b0, r3_wa1, 1'b0, r3_wa0}
                  : {r4_wa3, r4_wa2, r4_wa1, r4_wa0};
  end

  typedef struct {
    int          cyc;
    logic [15:0] a;
    int          tw;
    int          stg;
  } acc_t;

  acc_t rd_q[$];
  acc_t wr_q[$];
  logic [63:0] exp_busy, exp_done, exp_bsel;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, c, act, exp);
    end
  endtask

  // Expected schedule for one transform whose iSTART is accepted in cycle a
  task automatic build(input int nl, input int a);
    int n, q4, s4, nstg, per, done_off, q, g, j, base;
    acc_t r, w;
    n = 1 << nl;
    q4 = n / 4;
    s4 = nl / 2;
    nstg = s4 + nl % 2;
    per = q4 + 2;
    done_off = nstg * per + 1;
    for (int s = 0; s < nstg; s++) begin
      for (int k = 0; k < q4; k++) begin
        r.cyc = a + 1 + s * per + k;
        r.stg = s;
        r.a = '0;
        if (s < s4) begin
          q = n >> (2 * s + 2);
          g = k / q;
          j = k % q;
          base = 4 * g * q + j;
          for (int m = 0; m < 4; m++) r.a[m*4 +: 4] = 4'(base + m * q);
          r.tw = (j << (2 * s)) % q4;
        end else begin
          for (int m = 0; m < 4; m++) r.a[m*4 +: 4] = 4'(4 * k + m);
          r.tw = 0;
          exp_bsel[r.cyc + 1] = 1'b1;
        end
        rd_q.push_back(r);
        w = r;
        w.cyc = r.cyc + 2;
        wr_q.push_back(w);
      end
    end
    for (int c = a + 1; c <= a + done_off; c++) exp_busy[c] = 1'b1;
    exp_done[a + done_off] = 1'b1;
  endtask

  task automatic run_case(input bit u3, input logic [63:0] smask, input int acc0, input int acc1,
                          input int ncyc, output int nrd, output int nwr, output int ndn);
    acc_t e;
    int nl;
    nrd = 0; nwr = 0; ndn = 0;
    sel3 = u3;
    rd_q.delete();
    wr_q.delete();
    exp_busy = '0; exp_done = '0; exp_bsel = '0;
    nl = u3 ? 3 : 4;
    build(nl, acc0);
    if (acc1 >= 0) build(nl, acc1);
    @(posedge clk); #1;
    for (int c = 0; c < ncyc; c++) begin
      start = smask[c];
      @(negedge clk);
      chk("busy", c, 32'(o_busy), 32'(exp_busy[c]));
      chk("done", c, 32'(o_done), 32'(exp_done[c]));
      chk("but_sel", c, 32'(o_bsel), 32'(exp_bsel[c]));
      if (o_rd_en) begin
        nrd++;
        chk("rd_expected", c, 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          e = rd_q.pop_front();
          chk("rd_cycle", c, 32'(c), 32'(e.cyc));
          chk("rd_addr", c, 32'(o_ra), 32'(e.a));
          chk("tw_idx", c, 32'(o_tw), 32'(e.tw));
          chk("stage", c, 32'(o_stg), 32'(e.stg));
        end
      end else begin
        chk("tw_idle", c, 32'(o_tw), 32'd0);
      end
      if (o_we) begin
        nwr++;
        chk("wr_expected", c, 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_cycle", c, 32'(c), 32'(e.cyc));
          chk("wr_addr", c, 32'(o_wa), 32'(e.a));
        end
      end
      if (o_done) ndn++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("rd_left", ncyc, 32'(rd_q.size()), 32'd0);
    chk("wr_left", ncyc, 32'(wr_q.size()), 32'd0);
  endtask

  typedef struct {
    bit          u3;
    logic [63:0] smask;
    int          acc0;
    int          acc1;
    int          ncyc;
    int          exp_rd;
    int          exp_wr;
    int          exp_dn;
    int          exp_cycles;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int nrd, nwr, ndn;
    int ncyc_hold;

    // single run N=16; N=8 with radix-2 tail; extra pulses at 3 and in DONE; start held through DONE
    tbl[0] = '{1'b0, 64'h1,    0, -1, 20, 8, 8, 1, 13};
    tbl[1] = '{1'b1, 64'h1,    0, -1, 14, 4, 4, 1, 9};
    tbl[2] = '{1'b0, 64'h2009, 0, -1, 20, 8, 8, 1, 13};
    tbl[3] = '{1'b0, 64'h3FFF, 0, -1, 20, 8, 8, 1, 13};

    rst_n = 1'b0;
    start = 1'b0;
    sel3  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 0, 32'(o_busy), 32'd0);
    chk("rst_rd_en", 0, 32'(o_rd_en), 32'd0);
    chk("rst_we", 0, 32'(o_we), 32'd0);
    chk("rst_done", 0, 32'(o_done), 32'd0);
    chk("rst_stage", 0, 32'(o_stg), 32'd0);
    chk("rst_rd_addr", 0, 32'(o_ra), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_case(tbl[i].u3, tbl[i].smask, tbl[i].acc0, tbl[i].acc1, tbl[i].ncyc, nrd, nwr, ndn);
      chk("tbl_reads", i, 32'(nrd), 32'(tbl[i].exp_rd));
      chk("tbl_writes", i, 32'(nwr), 32'(tbl[i].exp_wr));
      chk("tbl_dones", i, 32'(ndn), 32'(tbl[i].exp_dn));
`ifdef FFT_SCHED_CYCLE_CNT_EN
      chk("cycles_held", i, 32'(tbl[i].u3 ? r3_cyc : r4_cyc), 32'(tbl[i].exp_cycles));
`endif
    end

    // Pulse in the DONE cycle is ignored; pulse one cycle later starts a second run
    run_case(1'b0, 64'h6001, 0, 14, 34, nrd, nwr, ndn);
    chk("restart_reads", 0, 32'(nrd), 32'd16);
    chk("restart_writes", 0, 32'(nwr), 32'd16);
    chk("restart_dones", 0, 32'(ndn), 32'd2);
`ifdef FFT_SCHED_CYCLE_CNT_EN
    chk("restart_cycles", 0, 32'(r4_cyc), 32'd13);
`endif

    // Asynchronous reset in cycle 5 of an N=16 run
    sel3 = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_we", 5, 32'(o_we), 32'd1);
    chk("pre_rst_busy", 5, 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 5, 32'(o_busy), 32'd0);
    chk("arst_we", 5, 32'(o_we), 32'd0);
    chk("arst_rd_en", 5, 32'(o_rd_en), 32'd0);
    chk("arst_rd_addr", 5, 32'(o_ra), 32'd0);
    chk("arst_wr_addr", 5, 32'(o_wa), 32'd0);
    chk("arst_stage", 5, 32'(o_stg), 32'd0);
    chk("arst_tw", 5, 32'(o_tw), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    ncyc_hold = 10;
    for (int c = 0; c < ncyc_hold; c++) begin
      @(negedge clk);
      chk("post_rst_we", c, 32'(o_we), 32'd0);
      chk("post_rst_rd_en", c, 32'(o_rd_en), 32'd0);
      chk("post_rst_busy", c, 32'(o_busy), 32'd0);
    end
    run_case(1'b0, 64'h1, 0, -1, 20, nrd, nwr, ndn);
    chk("clean_reads", 0, 32'(nrd), 32'd8);
    chk("clean_writes", 0, 32'(nwr), 32'd8);
    chk("clean_dones", 0, 32'(ndn), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
